// File: rtl/ahb_sram_slave.sv
// AHB slave with a 64-bit on-chip memory.
// It supports a configurable number of wait states per OKAY transfer, and it
// returns the two-cycle ERROR response for illegal size or alignment.
module ahb_sram_slave #(
    parameter int ADDR_WIDTH  = 16,
    parameter int WAIT_STATES = 0
) (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic        HSELx,
    input  logic [31:0] HADDR,
    input  logic [1:0]  HTRANS,
    input  logic        HWRITE,
    input  logic [2:0]  HSIZE,
    input  logic [63:0] HWDATA,
    input  logic        HREADY,
    output logic        HREADYOUT,
    output logic [1:0]  HRESP,
    output logic [63:0] HRDATA
);

    localparam int WORD_AW = ADDR_WIDTH - 3;
    localparam int DEPTH   = 1 << WORD_AW;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_ERR1,
        ST_ERR2
    } state_t;

    state_t                  state;
    logic [1:0]              wait_cnt;
    logic                    dphase;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic                    write_q;
    logic [1:0]              size_q;
    logic [63:0]             mem [DEPTH];

    logic                    accept;
    logic                    illegal;
    logic                    complete;
    logic [7:0]              be;
    logic                    unused_bits;

    // Size above doubleword, or an address not aligned to the transfer size.
    function automatic logic is_illegal(input logic [2:0] size, input logic [2:0] a);
        logic bad;
        case (size)
            3'd0:    bad = 1'b0;
            3'd1:    bad = a[0];
            3'd2:    bad = |a[1:0];
            3'd3:    bad = |a;
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

    // Little-endian lane enables for a legal, aligned transfer.
    function automatic logic [7:0] byte_en(input logic [1:0] size, input logic [2:0] a);
        logic [7:0] en;
        case (size)
            2'd0:    en = 8'b0000_0001 << a;
            2'd1:    en = 8'b0000_0011 << {a[2:1], 1'b0};
            2'd2:    en = a[2] ? 8'hF0 : 8'h0F;
            default: en = 8'hFF;
        endcase
        return en;
    endfunction

    // Address bits above the decoded range and HTRANS[0] do not affect behaviour.
    assign unused_bits = ^{HADDR[31:ADDR_WIDTH], HTRANS[0]};

    // A new address phase is only taken while this slave is itself ready.
    assign accept   = HSELx & HREADY & HTRANS[1] & HREADYOUT;
    assign illegal  = is_illegal(HSIZE, HADDR[2:0]);
    assign complete = (state == ST_IDLE) & dphase;
    assign be       = byte_en(size_q, addr_q[2:0]);

    // Transfer-state FSM with registered ready/response outputs.
    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            state     <= ST_IDLE;
            wait_cnt  <= 2'd0;
            dphase    <= 1'b0;
            HREADYOUT <= 1'b1;
            HRESP     <= 2'b00;
        end else begin
            case (state)
                ST_IDLE, ST_ERR2: begin
                    if (accept && illegal) begin
                        state     <= ST_ERR1;
                        dphase    <= 1'b0;
                        HREADYOUT <= 1'b0;
                        HRESP     <= 2'b01;
                    end else if (accept) begin
                        dphase <= 1'b1;
                        HRESP  <= 2'b00;
                        if (WAIT_STATES > 0) begin
                            state     <= ST_WAIT;
                            wait_cnt  <= 2'(WAIT_STATES);
                            HREADYOUT <= 1'b0;
                        end else begin
                            state     <= ST_IDLE;
                            HREADYOUT <= 1'b1;
                        end
                    end else begin
                        state     <= ST_IDLE;
                        dphase    <= 1'b0;
                        HREADYOUT <= 1'b1;
                        HRESP     <= 2'b00;
                    end
                end
                ST_WAIT: begin
                    wait_cnt <= wait_cnt - 2'd1;
                    if (wait_cnt == 2'd1) begin
                        state     <= ST_IDLE;
                        HREADYOUT <= 1'b1;
                    end
                end
                ST_ERR1: begin
                    state     <= ST_ERR2;
                    HREADYOUT <= 1'b1;
                    HRESP     <= 2'b01;
                end
                default: begin
                    state     <= ST_IDLE;
                    dphase    <= 1'b0;
                    HREADYOUT <= 1'b1;
                    HRESP     <= 2'b00;
                end
            endcase
        end
    end

    // Capture address-phase controls for the data phase of a legal transfer.
    always_ff @(posedge HCLK) begin
        if (accept && !illegal) begin
            addr_q  <= HADDR[ADDR_WIDTH-1:0];
            write_q <= HWRITE;
            size_q  <= HSIZE[1:0];
        end
    end

    // Commit write data at the edge ending the completing data cycle.
    always_ff @(posedge HCLK) begin
        if (HRESETn && complete && write_q) begin
            for (int i = 0; i < 8; i++) begin
                if (be[i]) begin
                    mem[addr_q[ADDR_WIDTH-1:3]][8*i +: 8] <= HWDATA[8*i +: 8];
                end
            end
        end
    end

    // Read data is presented only during a read's completing data cycle.
    always_comb begin
        HRDATA = 64'd0;
        if (complete && !write_q) begin
            HRDATA = mem[addr_q[ADDR_WIDTH-1:3]];
        end
    end

endmodule
